// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port scheduler: round-robin arbitration between two writeback requesters plus a busy scoreboard.
// Optional `REGFILE_WB_SCHED_BYPASS_EN adds same-cycle forwarding of the write-port data into the hazard check.
module regfile_wb_scheduler #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                reserve_valid,
  input  logic [ADDR_W-1:0]   reserve_dr,
  input  logic [ADDR_W-1:0]   chk_sr1,
  input  logic [ADDR_W-1:0]   chk_sr2,
  input  logic                chk_use_sr2,
  output logic                stall,
  input  logic                wb_a_valid,
  input  logic [ADDR_W-1:0]   wb_a_dr,
  input  logic [DATA_W-1:0]   wb_a_data,
  output logic                wb_a_ready,
  input  logic                wb_b_valid,
  input  logic [ADDR_W-1:0]   wb_b_dr,
  input  logic [DATA_W-1:0]   wb_b_data,
  output logic                wb_b_ready,
  output logic [ADDR_W-1:0]   DRMUX,
  output logic [DATA_W-1:0]   BUSINPUT,
  output logic                LD_REG,
`ifdef REGFILE_WB_SCHED_BYPASS_EN
  output logic                fwd_sr1_hit,
  output logic                fwd_sr2_hit,
  output logic [DATA_W-1:0]   fwd_data,
`endif
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_eff;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [NUM_REGS-1:0] clr_mask;
  logic                rr_ptr;
  logic                grant_a;
  logic                grant_b;
  logic                reserve_accept;

  // A lone requester always wins; the pointer only breaks ties.
  assign grant_a = !Reset && wb_a_valid && (!wb_b_valid || !rr_ptr);
  assign grant_b = !Reset && wb_b_valid && (!wb_a_valid ||  rr_ptr);

  assign wb_a_ready = grant_a;
  assign wb_b_ready = grant_b;
  assign LD_REG     = grant_a || grant_b;

  always_comb begin
    DRMUX    = '0;
    BUSINPUT = '0;
    if (grant_a) begin
      DRMUX    = wb_a_dr;
      BUSINPUT = wb_a_data;
    end else if (grant_b) begin
      DRMUX    = wb_b_dr;
      BUSINPUT = wb_b_data;
    end
  end

  always_comb begin
    clr_mask = '0;
    if (LD_REG) clr_mask[DRMUX] = 1'b1;
  end

`ifdef REGFILE_WB_SCHED_BYPASS_EN
  // A register being written this cycle is forwarded, so it no longer blocks issue.
  assign busy_eff    = busy & ~clr_mask;
  assign fwd_sr1_hit = LD_REG && (DRMUX == chk_sr1);
  assign fwd_sr2_hit = LD_REG && chk_use_sr2 && (DRMUX == chk_sr2);
  assign fwd_data    = BUSINPUT;
`else
  assign busy_eff = busy;
`endif

  assign stall = reserve_valid &&
                 (busy_eff[chk_sr1] || (chk_use_sr2 && busy_eff[chk_sr2]) || busy_eff[reserve_dr]);
  assign reserve_accept = reserve_valid && !stall;

  // Clear first, then set, so a same-cycle reserve of the written register wins.
  always_comb begin
    busy_nxt = busy & ~clr_mask;
    if (reserve_accept) busy_nxt[reserve_dr] = 1'b1;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      busy   <= '0;
      rr_ptr <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (grant_a)      rr_ptr <= 1'b1;
      else if (grant_b) rr_ptr <= 1'b0;
    end
  end

  assign busy_vec = busy;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed self-checking bench for regfile_wb_scheduler (both default and bypass builds).
module tb_regfile_wb_scheduler;
  localparam int DATA_W = 16;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  logic Reset;
  logic reserve_valid;
  logic [ADDR_W-1:0] reserve_dr, chk_sr1, chk_sr2;
  logic chk_use_sr2;
  logic stall;
  logic wb_a_valid, wb_b_valid, wb_a_ready, wb_b_ready;
  logic [ADDR_W-1:0] wb_a_dr, wb_b_dr, DRMUX;
  logic [DATA_W-1:0] wb_a_data, wb_b_data, BUSINPUT;
  logic LD_REG;
  logic [NUM_REGS-1:0] busy_vec;
`ifdef REGFILE_WB_SCHED_BYPASS_EN
  logic fwd_sr1_hit, fwd_sr2_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .Reset(Reset),
    .reserve_valid(reserve_valid), .reserve_dr(reserve_dr),
    .chk_sr1(chk_sr1), .chk_sr2(chk_sr2), .chk_use_sr2(chk_use_sr2), .stall(stall),
    .wb_a_valid(wb_a_valid), .wb_a_dr(wb_a_dr), .wb_a_data(wb_a_data), .wb_a_ready(wb_a_ready),
    .wb_b_valid(wb_b_valid), .wb_b_dr(wb_b_dr), .wb_b_data(wb_b_data), .wb_b_ready(wb_b_ready),
    .DRMUX(DRMUX), .BUSINPUT(BUSINPUT), .LD_REG(LD_REG),
`ifdef REGFILE_WB_SCHED_BYPASS_EN
    .fwd_sr1_hit(fwd_sr1_hit), .fwd_sr2_hit(fwd_sr2_hit), .fwd_data(fwd_data),
`endif
    .busy_vec(busy_vec)
  );

  task automatic test_reset;
    Reset = 1'b1; reserve_valid = 1'b0; reserve_dr = '0; chk_sr1 = '0; chk_sr2 = '0; chk_use_sr2 = 1'b0;
    wb_a_valid = 1'b1; wb_a_dr = 3'd1; wb_a_data = 16'h1111;
    wb_b_valid = 1'b1; wb_b_dr = 3'd2; wb_b_data = 16'h2222;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (busy_vec !== 8'h00) begin failures++; $display("FAIL reset_busy got=%h exp=%h", busy_vec, 8'h00); end
    checks++; if (LD_REG !== 1'b0) begin failures++; $display("FAIL reset_ld_reg got=%b exp=0", LD_REG); end
    checks++; if ({wb_a_ready, wb_b_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {wb_a_ready, wb_b_ready}); end
    checks++; if (DRMUX !== 3'd0 || BUSINPUT !== 16'h0) begin failures++; $display("FAIL reset_port got=%0d/%h exp=0/0000", DRMUX, BUSINPUT); end
    wb_a_valid = 1'b0; wb_b_valid = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
  endtask

  task automatic test_reserve;
    @(negedge clk);
    reserve_valid = 1'b1; reserve_dr = 3'd3; chk_sr1 = 3'd1; chk_sr2 = 3'd2; chk_use_sr2 = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reserve_stall got=%b exp=0", stall); end
    @(negedge clk);
    reserve_valid = 1'b0;
    #1;
    checks++; if (busy_vec !== 8'h08) begin failures++; $display("FAIL reserve_busy got=%h exp=08", busy_vec); end
    // SR2 busy but unused (imm5) must not stall; used must stall
    reserve_valid = 1'b1; reserve_dr = 3'd0; chk_sr1 = 3'd1; chk_sr2 = 3'd3; chk_use_sr2 = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL imm5_stall got=%b exp=0", stall); end
    chk_use_sr2 = 1'b1;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sr2_raw_stall got=%b exp=1", stall); end
    reserve_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL idle_stall got=%b exp=0", stall); end
  endtask

  task automatic test_raw_clear;
    @(negedge clk);
    reserve_valid = 1'b1; reserve_dr = 3'd0; chk_sr1 = 3'd3; chk_sr2 = 3'd0; chk_use_sr2 = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL raw_stall got=%b exp=1", stall); end
    reserve_valid = 1'b0;
    @(negedge clk);
    wb_a_valid = 1'b1; wb_a_dr = 3'd3; wb_a_data = 16'h1234;
    #1;
    checks++; if ({wb_a_ready, wb_b_ready, LD_REG} !== 3'b101) begin failures++; $display("FAIL wb_a_grant got=%b exp=101", {wb_a_ready, wb_b_ready, LD_REG}); end
    checks++; if (DRMUX !== 3'd3 || BUSINPUT !== 16'h1234) begin failures++; $display("FAIL wb_a_port got=%0d/%h exp=3/1234", DRMUX, BUSINPUT); end
    @(negedge clk);
    wb_a_valid = 1'b0;
    reserve_valid = 1'b1; reserve_dr = 3'd0; chk_sr1 = 3'd3;
    #1;
    checks++; if (busy_vec !== 8'h00) begin failures++; $display("FAIL clear_busy got=%h exp=00", busy_vec); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL clear_stall got=%b exp=0", stall); end
    checks++; if (LD_REG !== 1'b0) begin failures++; $display("FAIL idle_ld_reg got=%b exp=0", LD_REG); end
    reserve_valid = 1'b0;
  endtask

  task automatic test_lone_b;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wb_b_valid = 1'b1; wb_b_dr = 3'd2; wb_b_data = 16'hB100 + 16'(i);
      #1;
      checks++; if ({wb_a_ready, wb_b_ready, LD_REG} !== 3'b011) begin failures++; $display("FAIL lone_b_grant%0d got=%b exp=011", i, {wb_a_ready, wb_b_ready, LD_REG}); end
      checks++; if (DRMUX !== 3'd2 || BUSINPUT !== 16'hB100 + 16'(i)) begin failures++; $display("FAIL lone_b_port%0d got=%0d/%h exp=2/%h", i, DRMUX, BUSINPUT, 16'hB100 + 16'(i)); end
    end
    @(negedge clk);
    wb_b_valid = 1'b0;
    #1;
    checks++; if (busy_vec !== 8'h00) begin failures++; $display("FAIL lone_b_busy got=%h exp=00", busy_vec); end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wb_a_valid = 1'b1; wb_a_dr = 3'd1; wb_a_data = 16'hA000 + 16'(i);
      wb_b_valid = 1'b1; wb_b_dr = 3'd2; wb_b_data = 16'hB000 + 16'(i);
      #1;
      if (i % 2 == 0) begin
        checks++; if ({wb_a_ready, wb_b_ready, LD_REG} !== 3'b101) begin failures++; $display("FAIL rr_grant%0d got=%b exp=101", i, {wb_a_ready, wb_b_ready, LD_REG}); end
        checks++; if (DRMUX !== 3'd1 || BUSINPUT !== 16'hA000 + 16'(i)) begin failures++; $display("FAIL rr_port%0d got=%0d/%h exp=1/%h", i, DRMUX, BUSINPUT, 16'hA000 + 16'(i)); end
      end else begin
        checks++; if ({wb_a_ready, wb_b_ready, LD_REG} !== 3'b011) begin failures++; $display("FAIL rr_grant%0d got=%b exp=011", i, {wb_a_ready, wb_b_ready, LD_REG}); end
        checks++; if (DRMUX !== 3'd2 || BUSINPUT !== 16'hB000 + 16'(i)) begin failures++; $display("FAIL rr_port%0d got=%0d/%h exp=2/%h", i, DRMUX, BUSINPUT, 16'hB000 + 16'(i)); end
      end
    end
    @(negedge clk);
    wb_a_valid = 1'b0; wb_b_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    reserve_valid = 1'b1; reserve_dr = 3'd5; chk_sr1 = 3'd0; chk_sr2 = 3'd0; chk_use_sr2 = 1'b0;
    @(negedge clk);
    reserve_dr = 3'd6;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reserve_r6_stall got=%b exp=0", stall); end
    @(negedge clk);
    reserve_dr = 3'd5;
    #1;
    checks++; if (busy_vec !== 8'h60) begin failures++; $display("FAIL busy_r5_r6 got=%h exp=60", busy_vec); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL waw_stall got=%b exp=1", stall); end
    reserve_valid = 1'b0;
    // Lone A transfer leaves the pointer favouring B
    wb_a_valid = 1'b1; wb_a_dr = 3'd1; wb_a_data = 16'h0001;
    @(negedge clk);
    wb_a_dr = 3'd5; wb_a_data = 16'h5555;
    wb_b_valid = 1'b1; wb_b_dr = 3'd6; wb_b_data = 16'h6666;
    #1;
    checks++; if ({wb_a_ready, wb_b_ready} !== 2'b01) begin failures++; $display("FAIL pre_reset_grant got=%b exp=01", {wb_a_ready, wb_b_ready}); end
    Reset = 1'b1;
    #1;
    checks++; if (LD_REG !== 1'b0) begin failures++; $display("FAIL mid_reset_ld_reg got=%b exp=0", LD_REG); end
    checks++; if (busy_vec !== 8'h00) begin failures++; $display("FAIL mid_reset_busy got=%h exp=00", busy_vec); end
    checks++; if ({wb_a_ready, wb_b_ready} !== 2'b00) begin failures++; $display("FAIL mid_reset_ready got=%b exp=00", {wb_a_ready, wb_b_ready}); end
    @(negedge clk);
    Reset = 1'b0;
    #1;
    checks++; if ({wb_a_ready, wb_b_ready, LD_REG} !== 3'b101) begin failures++; $display("FAIL post_reset_grant got=%b exp=101", {wb_a_ready, wb_b_ready, LD_REG}); end
    checks++; if (DRMUX !== 3'd5 || BUSINPUT !== 16'h5555) begin failures++; $display("FAIL post_reset_port got=%0d/%h exp=5/5555", DRMUX, BUSINPUT); end
    @(negedge clk);
    wb_a_valid = 1'b0;
    #1;
    checks++; if ({wb_a_ready, wb_b_ready, DRMUX} !== {2'b01, 3'd6}) begin failures++; $display("FAIL post_reset_b got=%b/%0d exp=01/6", {wb_a_ready, wb_b_ready}, DRMUX); end
    @(negedge clk);
    wb_b_valid = 1'b0;
  endtask

  task automatic test_bypass;
    @(negedge clk);
    reserve_valid = 1'b1; reserve_dr = 3'd4; chk_sr1 = 3'd0; chk_sr2 = 3'd0; chk_use_sr2 = 1'b0;
    @(negedge clk);
    reserve_valid = 1'b1; reserve_dr = 3'd0; chk_sr1 = 3'd1; chk_sr2 = 3'd4; chk_use_sr2 = 1'b1;
    wb_b_valid = 1'b1; wb_b_dr = 3'd4; wb_b_data = 16'hBEEF;
    #1;
    checks++; if (wb_b_ready !== 1'b1) begin failures++; $display("FAIL byp_b_ready got=%b exp=1", wb_b_ready); end
`ifdef REGFILE_WB_SCHED_BYPASS_EN
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL byp_stall got=%b exp=0", stall); end
    checks++; if ({fwd_sr1_hit, fwd_sr2_hit} !== 2'b01) begin failures++; $display("FAIL byp_hits got=%b exp=01", {fwd_sr1_hit, fwd_sr2_hit}); end
    checks++; if (fwd_data !== 16'hBEEF) begin failures++; $display("FAIL byp_data got=%h exp=beef", fwd_data); end
`else
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL nobyp_stall got=%b exp=1", stall); end
`endif
    @(negedge clk);
    reserve_valid = 1'b0; wb_b_valid = 1'b0;
    #1;
`ifdef REGFILE_WB_SCHED_BYPASS_EN
    checks++; if (busy_vec !== 8'h01) begin failures++; $display("FAIL byp_busy got=%h exp=01", busy_vec); end
`else
    checks++; if (busy_vec !== 8'h00) begin failures++; $display("FAIL nobyp_busy got=%h exp=00", busy_vec); end
`endif
    wb_a_valid = 1'b1; wb_a_dr = 3'd0; wb_a_data = 16'h0;
    @(negedge clk);
    wb_a_valid = 1'b0;
    #1;
    checks++; if (busy_vec !== 8'h00) begin failures++; $display("FAIL final_busy got=%h exp=00", busy_vec); end
  endtask

  initial begin
    test_reset();
    test_reserve();
    test_raw_clear();
    test_lone_b();
    test_back_to_back();
    test_reset_mid();
    test_bypass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
